// File: rtl/ibex_ascon_perm.sv
// Iterative Ascon-p permutation engine: 0-12 rounds at UNROLL rounds per clock,
// with a valid/ready request side and a held result until the consumer accepts it.

package ibex_ascon_defines;
    localparam int unsigned LINE_W  = 64;
    localparam int unsigned HALF_W  = LINE_W / 2;
    localparam int unsigned STATE_W = 5 * LINE_W;

    typedef struct packed {
        logic [HALF_W-1:0] x_hi;
        logic [HALF_W-1:0] x_low;
    } ascon_line_t;

    typedef struct packed {
        ascon_line_t x0;
        ascon_line_t x1;
        ascon_line_t x2;
        ascon_line_t x3;
        ascon_line_t x4;
    } ascon_state_t;
endpackage

module ibex_ascon_perm
    import ibex_ascon_defines::*;
#(
    parameter int unsigned UNROLL = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  ascon_state_t state_i,
    input  logic [3:0]   rounds_i,
    input  logic         flush_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output ascon_state_t state_o,
    output logic         busy_o
);

    localparam int unsigned RND_W = 4;
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(12);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    ascon_state_t     state_q, state_d;

    logic [RND_W-1:0] rounds_sat;
    logic [RND_W-1:0] step;
    logic [RND_W-1:0] rnd_next;
    ascon_state_t     round1;
    ascon_state_t     stepped;
    logic             accept;

    function automatic logic [LINE_W-1:0] rotr(input logic [LINE_W-1:0] v,
                                               input int unsigned n);
        return (v >> n) | (v << (LINE_W - n));
    endfunction

    // One Ascon-p round: constant addition, bitsliced S-box, linear diffusion.
    function automatic ascon_state_t ascon_round(input ascon_state_t s,
                                                 input logic [RND_W-1:0] idx);
        logic [LINE_W-1:0] a0, a1, a2, a3, a4;
        logic [LINE_W-1:0] t0, t1, t2, t3, t4;
        ascon_state_t      r;
        a0 = s.x0;
        a1 = s.x1;
        a2 = s.x2;
        a3 = s.x3;
        a4 = s.x4;
        a2[7:0] = a2[7:0] ^ {4'(4'hF - idx), idx};
        a0 = a0 ^ a4;
        a4 = a4 ^ a3;
        a2 = a2 ^ a1;
        t0 = ~a0 & a1;
        t1 = ~a1 & a2;
        t2 = ~a2 & a3;
        t3 = ~a3 & a4;
        t4 = ~a4 & a0;
        a0 = a0 ^ t1;
        a1 = a1 ^ t2;
        a2 = a2 ^ t3;
        a3 = a3 ^ t4;
        a4 = a4 ^ t0;
        a1 = a1 ^ a0;
        a0 = a0 ^ a4;
        a3 = a3 ^ a2;
        a2 = ~a2;
        r.x0 = a0 ^ rotr(a0, 19) ^ rotr(a0, 28);
        r.x1 = a1 ^ rotr(a1, 61) ^ rotr(a1, 39);
        r.x2 = a2 ^ rotr(a2, 1)  ^ rotr(a2, 6);
        r.x3 = a3 ^ rotr(a3, 10) ^ rotr(a3, 17);
        r.x4 = a4 ^ rotr(a4, 7)  ^ rotr(a4, 41);
        return r;
    endfunction

    assign rounds_sat = (rounds_i > LAST_RND) ? LAST_RND : rounds_i;
    assign accept     = (fsm_q == IDLE) && in_valid_i && !flush_i;
    assign round1     = ascon_round(state_q, rnd_q);

    // Second chained round is skipped when only one round remains.
    generate
        if (UNROLL == 2) begin : g_unroll2
            ascon_state_t round2;
            logic         two_left;
            assign round2   = ascon_round(round1, RND_W'(rnd_q + RND_W'(1)));
            assign two_left = (rnd_q <= RND_W'(10));
            assign stepped  = two_left ? round2 : round1;
            assign step     = two_left ? RND_W'(2) : RND_W'(1);
        end else begin : g_unroll1
            assign stepped = round1;
            assign step    = RND_W'(1);
        end
    endgenerate

    assign rnd_next = RND_W'(rnd_q + step);

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // FSM next-state logic; flush overrides every other transition
    always_comb begin
        fsm_d = fsm_q;
        if (flush_i) begin
            fsm_d = IDLE;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                    if (in_valid_i) begin
                        fsm_d = (rounds_sat == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (rnd_next == LAST_RND) begin
                        fsm_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        fsm_d = IDLE;
                    end
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    // FSM output decode
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        unique case (fsm_q)
            IDLE:    in_ready_o  = 1'b1;
            RUN:     busy_o      = 1'b1;
            DONE: begin
                out_valid_o = 1'b1;
                busy_o      = 1'b1;
            end
            default: in_ready_o  = 1'b0;
        endcase
    end

    // Datapath next values: load on accept, advance while running, else hold
    always_comb begin
        rnd_d   = rnd_q;
        state_d = state_q;
        if (accept) begin
            rnd_d   = RND_W'(LAST_RND - rounds_sat);
            state_d = state_i;
        end else if ((fsm_q == RUN) && !flush_i) begin
            rnd_d   = rnd_next;
            state_d = stepped;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rnd_q   <= '0;
            state_q <= '0;
        end else begin
            rnd_q   <= rnd_d;
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_ibex_ascon_perm.sv
// Bench for ibex_ascon_perm: UNROLL=1 and UNROLL=2 instances share stimulus and are
// checked against a table-driven Ascon-p reference through per-instance scoreboards.

module tb_ibex_ascon_perm;

    localparam logic [4:0] SBOX [32] = '{
        5'd4,  5'd11, 5'd31, 5'd20, 5'd26, 5'd21, 5'd9,  5'd2,
        5'd27, 5'd5,  5'd8,  5'd18, 5'd29, 5'd3,  5'd6,  5'd28,
        5'd30, 5'd19, 5'd7,  5'd14, 5'd0,  5'd13, 5'd17, 5'd24,
        5'd16, 5'd12, 5'd1,  5'd25, 5'd22, 5'd10, 5'd15, 5'd23
    };

    typedef struct {
        logic [319:0] st;
        int           lat;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [319:0] st_in;
    logic [3:0]   rounds;
    logic         flush;
    logic         out_ready;
    logic [1:0]   in_ready;
    logic [1:0]   ov;
    logic [1:0]   busy;
    logic [319:0] so [2];

    int   n_cmp;
    int   n_bad;
    exp_t q0[$];
    exp_t q1[$];

    ibex_ascon_perm #(.UNROLL(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
        .state_i(st_in), .rounds_i(rounds), .flush_i(flush), .out_valid_o(ov[0]),
        .out_ready_i(out_ready), .state_o(so[0]), .busy_o(busy[0])
    );

    ibex_ascon_perm #(.UNROLL(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
        .state_i(st_in), .rounds_i(rounds), .flush_i(flush), .out_valid_o(ov[1]),
        .out_ready_i(out_ready), .state_o(so[1]), .busy_o(busy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Reference Ascon-p over the last nr rounds, S-box via lookup table per column.
    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int nr);
        logic [63:0] x [5];
        logic [4:0]  c;
        logic [4:0]  o;
        logic [7:0]  rc;
        for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
        for (int i = 12 - nr; i < 12; i++) begin
            rc = 8'((15 - i) * 16 + i);
            x[2][7:0] = x[2][7:0] ^ rc;
            for (int b = 0; b < 64; b++) begin
                c = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                o = SBOX[c];
                for (int k = 0; k < 5; k++) x[k][b] = o[4-k];
            end
            x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
            x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
            x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
            x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
            x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] r;
        for (int w = 0; w < 10; w++) r[32*w +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid  = 1'($urandom);
            st_in     = rand_state();
            rounds    = 4'($urandom);
            flush     = 1'($urandom);
            out_ready = 1'($urandom);
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (in_ready[d] !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready dut%0d: got %b want 1", d, in_ready[d]); end
            n_cmp++; if (ov[d] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid dut%0d: got %b want 0", d, ov[d]); end
            n_cmp++; if (busy[d] !== 1'b0) begin n_bad++; $display("FAIL reset_busy dut%0d: got %b want 0", d, busy[d]); end
            n_cmp++; if (so[d] !== '0) begin n_bad++; $display("FAIL reset_state dut%0d: got %h want 0", d, so[d]); end
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        tick();
    endtask

    // One request through both engines; results popped from the scoreboards as they appear.
    task automatic test_transfer(input logic [319:0] s, input logic [3:0] r);
        int         rs;
        int         n;
        logic [1:0] done;
        exp_t       e;
        rs = (r > 4'd12) ? 12 : int'(r);
        e.st = ref_perm(s, rs);
        e.lat = rs + 1;
        q0.push_back(e);
        e.lat = (rs + 1) / 2 + 1;
        q1.push_back(e);
        n_cmp++; if (in_ready !== 2'b11) begin n_bad++; $display("FAIL accept_ready: got %b want 11", in_ready); end
        st_in     = s;
        rounds    = r;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n    = 1;
        done = 2'b00;
        while (done != 2'b11 && n <= 16) begin
            for (int d = 0; d < 2; d++) begin
                if (!done[d] && ov[d]) begin
                    if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
                    n_cmp++; if (so[d] !== e.st) begin n_bad++; $display("FAIL result R=%0d dut%0d: got %h want %h", r, d, so[d], e.st); end
                    n_cmp++; if (n !== e.lat) begin n_bad++; $display("FAIL latency R=%0d dut%0d: got %0d want %0d", r, d, n, e.lat); end
                    done[d] = 1'b1;
                end
            end
            tick();
            n++;
        end
        n_cmp++;
        if (done !== 2'b11) begin
            n_bad++;
            $display("FAIL result_timeout R=%0d: done %b want 11", r, done);
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic test_zero_rounds();
        for (int i = 0; i < 4; i++) test_transfer(rand_state(), 4'd0);
    endtask

    task automatic test_golden();
        logic [3:0] rlist [5];
        rlist = '{4'd1, 4'd6, 4'd8, 4'd12, 4'd15};
        for (int i = 0; i < 1000; i++) begin
            for (int j = 0; j < 5; j++) test_transfer(rand_state(), rlist[j]);
        end
    endtask

    task automatic test_back_pressure();
        logic [319:0] s;
        logic [319:0] e;
        int           n;
        s = rand_state();
        e = ref_perm(s, 12);
        out_ready = 1'b0;
        st_in     = s;
        rounds    = 4'd12;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (ov != 2'b11 && n < 20) begin
            tick();
            n++;
        end
        n_cmp++; if (n !== 13) begin n_bad++; $display("FAIL bp_latency: got %0d want 13", n); end
        in_valid = 1'b1;
        rounds   = 4'd0;
        for (int c = 0; c < 20; c++) begin
            st_in = rand_state();
            tick();
            n_cmp++; if (ov !== 2'b11) begin n_bad++; $display("FAIL bp_hold_valid cycle %0d: got %b want 11", c, ov); end
            n_cmp++; if (in_ready !== 2'b00) begin n_bad++; $display("FAIL bp_in_ready cycle %0d: got %b want 00", c, in_ready); end
            for (int d = 0; d < 2; d++) begin
                n_cmp++; if (so[d] !== e) begin n_bad++; $display("FAIL bp_hold_state dut%0d cycle %0d: got %h want %h", d, c, so[d], e); end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_cmp++; if (ov !== 2'b00) begin n_bad++; $display("FAIL bp_release_valid: got %b want 00", ov); end
        n_cmp++; if (in_ready !== 2'b11) begin n_bad++; $display("FAIL bp_release_ready: got %b want 11", in_ready); end
        n_cmp++; if (so[0] !== e) begin n_bad++; $display("FAIL bp_state_kept: got %h want %h", so[0], e); end
        tick();
        n_cmp++; if (ov !== 2'b00 || busy !== 2'b00) begin n_bad++; $display("FAIL bp_single_handshake: valid %b busy %b want 00 00", ov, busy); end
    endtask

    task automatic test_flush();
        logic [319:0] s;
        out_ready = 1'b1;
        st_in     = rand_state();
        rounds    = 4'd12;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (in_ready !== 2'b11) begin n_bad++; $display("FAIL flush_run_ready: got %b want 11", in_ready); end
        n_cmp++; if (ov !== 2'b00 || busy !== 2'b00) begin n_bad++; $display("FAIL flush_run_idle: valid %b busy %b want 00 00", ov, busy); end
        for (int c = 0; c < 14; c++) begin
            tick();
            n_cmp++; if (ov !== 2'b00) begin n_bad++; $display("FAIL flush_no_output cycle %0d: got %b want 00", c, ov); end
        end
        test_transfer(rand_state(), 4'd6);

        s         = rand_state();
        out_ready = 1'b0;
        st_in     = s;
        rounds    = 4'd0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (ov !== 2'b11) begin n_bad++; $display("FAIL flush_done_valid: got %b want 11", ov); end
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (ov !== 2'b00 || in_ready !== 2'b11) begin n_bad++; $display("FAIL flush_done_drop: valid %b ready %b want 00 11", ov, in_ready); end
        n_cmp++; if (so[1] !== s) begin n_bad++; $display("FAIL flush_state_kept: got %h want %h", so[1], s); end
        tick();
        n_cmp++; if (ov !== 2'b00) begin n_bad++; $display("FAIL flush_single_drop: got %b want 00", ov); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        st_in     = rand_state();
        rounds    = 4'd12;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (in_ready[d] !== 1'b1 || ov[d] !== 1'b0 || busy[d] !== 1'b0) begin
                n_bad++; $display("FAIL midreset_ctrl dut%0d: ready %b valid %b busy %b want 1 0 0", d, in_ready[d], ov[d], busy[d]);
            end
            n_cmp++; if (so[d] !== '0) begin n_bad++; $display("FAIL midreset_state dut%0d: got %h want 0", d, so[d]); end
        end
        for (int c = 0; c < 14; c++) begin
            tick();
            n_cmp++; if (ov !== 2'b00) begin n_bad++; $display("FAIL midreset_spurious cycle %0d: got %b want 00", c, ov); end
        end
        test_transfer(rand_state(), 4'd8);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        st_in     = '0;
        rounds    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_zero_rounds();
        test_golden();
        test_back_pressure();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
